restoring_divider: RTL and testbench

- Multi-cycle iterative integer divider, the subtractive counterpart of the combinational adder used in the datapath.
- Serves the execute stage for DIV/DIVU and produces quotient and remainder (HI/LO) over a start/done handshake.
- One restoring step per clock. The pipeline stalls on busy.

---
 rtl/restoring_divider_pkg.sv | 21 ++
 rtl/restoring_divider_step.sv | 29 ++
 rtl/restoring_divider.sv | 160 ++++++++++++++++
 tb/tb_restoring_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared constants for the restoring divider
//
// Purpose: FSM state encoding, default bus width and the iteration counter
//          width helper used by restoring_divider.
// Ports:   none (package).
package restoring_divider_pkg;

    localparam int DEFAULT_BUS_SIZE = 32;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // The counter runs from BUS_SIZE-1 down to 0, so $clog2(BUS_SIZE) bits suffice.
    function automatic int cnt_width(input int bus_size);
        return (bus_size <= 2) ? 1 : $clog2(bus_size);
    endfunction

endpackage

// File: rtl/restoring_divider_step.sv
// rtl/restoring_divider_step.sv - one combinational restoring division step
//
// Purpose: shift {rem, quo} left by one, trial-subtract the divisor from the
//          widened remainder and keep or restore it.
// Ports:   rem_i/quo_i     current partial remainder / quotient shift register
//          divisor_i       divisor magnitude
//          rem_o/quo_o     values after one step
module divider_step #(
    parameter int BUS_SIZE = 32
) (
    input  logic [BUS_SIZE-1:0] rem_i,
    input  logic [BUS_SIZE-1:0] quo_i,
    input  logic [BUS_SIZE-1:0] divisor_i,
    output logic [BUS_SIZE-1:0] rem_o,
    output logic [BUS_SIZE-1:0] quo_o
);

    logic [BUS_SIZE:0] rem_sh;
    logic [BUS_SIZE:0] trial;

    // rem < divisor going in, so the shifted remainder is < 2*divisor and the
    // trial difference always lies in (-2^B, 2^B): bit B is a reliable sign.
    assign rem_sh = {rem_i, quo_i[BUS_SIZE-1]};
    assign trial  = rem_sh - {1'b0, divisor_i};

    assign rem_o = trial[BUS_SIZE] ? rem_sh[BUS_SIZE-1:0] : trial[BUS_SIZE-1:0];
    assign quo_o = {quo_i[BUS_SIZE-2:0], ~trial[BUS_SIZE]};

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle restoring integer divider (DIV/DIVU)
//
// Purpose: signed/unsigned division, one restoring step per clock, results
//          presented with a one-cycle done pulse.
// Ports:   clk, reset_n                 clock, asynchronous active-low reset
//          start, is_signed             request and mode, sampled in IDLE
//          dividend, divisor            operands, sampled with start
//          busy, done                   operation in progress / result pulse
//          quotient, remainder          results, held until the next done
//          div_by_zero                  flag for the last operation
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int BUS_SIZE = DEFAULT_BUS_SIZE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                is_signed,
    input  logic [BUS_SIZE-1:0] dividend,
    input  logic [BUS_SIZE-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [BUS_SIZE-1:0] quotient,
    output logic [BUS_SIZE-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = cnt_width(BUS_SIZE);

    logic [1:0]          state_q,     state_d;
    logic                signed_q,    signed_d;
    logic                neg_quo_q,   neg_quo_d;
    logic                neg_rem_q,   neg_rem_d;
    logic [BUS_SIZE-1:0] quo_q,       quo_d;      // dividend in, quotient out
    logic [BUS_SIZE-1:0] dvs_q,       dvs_d;
    logic [BUS_SIZE-1:0] rem_q,       rem_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [BUS_SIZE-1:0] quotient_q,  quotient_d;
    logic [BUS_SIZE-1:0] remainder_q, remainder_d;
    logic                dbz_q,       dbz_d;

    logic [BUS_SIZE-1:0] step_rem;
    logic [BUS_SIZE-1:0] step_quo;

    divider_step #(
        .BUS_SIZE (BUS_SIZE)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        signed_d    = signed_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Resolved immediately; the pipeline never sees busy.
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        signed_d  = is_signed;
                        neg_quo_d = is_signed & (dividend[BUS_SIZE-1] ^ divisor[BUS_SIZE-1]);
                        neg_rem_d = is_signed & dividend[BUS_SIZE-1];
                        quo_d     = dividend;
                        dvs_d     = divisor;
                        busy_d    = 1'b1;
                        state_d   = S_PREP;
                    end
                end
            end
            S_PREP: begin
                // Wrapping negation: |min| becomes 2^(B-1) read as unsigned,
                // which is exactly what the unsigned core needs.
                if (signed_q && quo_q[BUS_SIZE-1]) quo_d = -quo_q;
                if (signed_q && dvs_q[BUS_SIZE-1]) dvs_d = -dvs_q;
                rem_d   = '0;
                cnt_d   = CNT_W'(BUS_SIZE - 1);
                state_d = S_ITER;
            end
            S_ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin // S_FIX
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            signed_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            signed_q    <= signed_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider
module tb_restoring_divider;

    localparam int B = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         is_signed;
    logic [B-1:0] dividend;
    logic [B-1:0] divisor;
    logic         busy;
    logic         done;
    logic [B-1:0] quotient;
    logic [B-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [B-1:0] q;
        logic [B-1:0] r;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    restoring_divider #(.BUS_SIZE(B)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse; also verifies that the
    // result outputs only move on done cycles (reset excepted).
    logic [B-1:0] prev_q, prev_r;
    logic         prev_z;
    bit           prev_ok = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ok = 1'b0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                end
            end else if (prev_ok) begin
                check("hold_outputs", {31'd0, (quotient !== prev_q) || (remainder !== prev_r) ||
                                       (div_by_zero !== prev_z)}, 32'd0);
            end
            if (reset_n) begin
                prev_q  = quotient;
                prev_r  = remainder;
                prev_z  = div_by_zero;
                prev_ok = 1'b1;
            end
        end
    end

    // Drive one request; returns just after the accepting edge.
    task automatic issue(input logic s, input logic [B-1:0] a, input logic [B-1:0] b,
                         input logic [B-1:0] eq, input logic [B-1:0] er, input logic ez,
                         input bit push);
        @(posedge clk);
        #1;
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        if (push) exp_q.push_back('{q: eq, r: er, z: ez});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts sample cycles until done; cycle 1 is the one right after the
    // accepting edge. Negative expectations skip that check.
    task automatic wait_done(input string name, input int exp_cycle, input int exp_busy);
        int n = 0;
        int nb = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (exp_cycle >= 0) check({name, "_latency"}, n, exp_cycle);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;

        // done first seen in the cycle after edge E(B+2): sample 35; busy for 34
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done("u100_7", 35, 34);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("sm7_2", 35, 34);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
        wait_done("s7_m2", 35, 34);
        issue(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b1);
        wait_done("uff_16", 35, 34);
        issue(1'b1, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("sm1_16", 35, 34);
        issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
        wait_done("u5_0", 1, 0);
        issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
        wait_done("s5_0", 1, 0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        wait_done("smin_m1", 35, 34);

        // Re-pulsed start while busy must not resample 50/5.
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_restart", -1, -1);

        // New request presented during the done cycle is accepted.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        exp_q.push_back('{q: 32'd10, r: 32'd0, z: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_in_done", 35, 34);

        // Abort mid-operation: outputs clear, no done follows.
        issue(1'b0, 32'd100, 32'd7, '0, '0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);

        issue(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b1);
        wait_done("after_reset", 35, 34);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
